// File: rtl/pwm_counter_ctrl.sv
// PWM timebase and configuration controller: register file, double-buffered settings,
// prescaled counter and period wrap interrupt feeding pwm_gen.
module pwm_counter_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [2:0]            addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      count_val_o,
  output logic [WIDTH-1:0]      period_o,
  output logic [WIDTH-1:0]      compare1_o,
  output logic [WIDTH-1:0]      compare2_o,
  output logic [1:0]            functions_o,
  output logic                  pwm_en_o,
  output logic                  period_irq_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [WIDTH-1:0]      CountOne = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PcOne    = PRESCALE_W'(1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  cnt_en_q, pwm_en_q, one_shot_q, overflow_q, irq_q;
  logic [1:0]            func_sh_q, func_q;
  logic [WIDTH-1:0]      period_sh_q, cmp1_sh_q, cmp2_sh_q;
  logic [WIDTH-1:0]      period_q, cmp1_q, cmp2_q;
  logic [PRESCALE_W-1:0] presc_sh_q, presc_q;
  logic [WIDTH-1:0]      rdata_q, rd_mux;
  logic                  rd_valid_q;

  logic             ctrl_wr, start_wr, stop_wr, cnt_rst, tick, at_end, wrap, copy;
  logic [WIDTH-1:0] eff_period;

  assign ctrl_wr    = wr_en_i && (addr_i == 3'd0);
  assign start_wr   = ctrl_wr && wdata_i[0];
  assign stop_wr    = ctrl_wr && !wdata_i[0];
  assign cnt_rst    = ctrl_wr && wdata_i[5];
  assign eff_period = (period_q == '0) ? CountOne : period_q;
  assign tick       = (pc_q == presc_q);
  // >= rather than == so a period that shrank below the count still wraps.
  assign at_end     = (count_q >= (eff_period - CountOne));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    wrap    = 1'b0;
    copy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        copy = 1'b1;
        if (start_wr) state_d = StLoad;
      end
      StLoad: begin
        copy    = 1'b1;
        count_d = '0;
        pc_d    = '0;
        state_d = stop_wr ? StIdle : StRun;
      end
      StRun: begin
        if (stop_wr) begin
          state_d = StIdle;
        end else if (tick) begin
          pc_d = '0;
          if (at_end) wrap = 1'b1;
          else        count_d = count_q + CountOne;
        end else begin
          pc_d = pc_q + PcOne;
        end
      end
      default: state_d = StIdle;
    endcase
    // A counter reset swallows a coinciding wrap entirely.
    if (cnt_rst) begin
      count_d = '0;
      pc_d    = '0;
      wrap    = 1'b0;
    end
    if (wrap) begin
      count_d = '0;
      copy    = 1'b1;
      if (one_shot_q) state_d = StIdle;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr_i)
      3'd0: rd_mux[5:0] = {1'b0, one_shot_q, func_sh_q, pwm_en_q, cnt_en_q};
      3'd1: rd_mux = period_sh_q;
      3'd2: rd_mux = cmp1_sh_q;
      3'd3: rd_mux = cmp2_sh_q;
      3'd4: rd_mux[PRESCALE_W-1:0] = presc_sh_q;
      3'd5: rd_mux[1:0] = {overflow_q, state_q != StIdle};
      3'd6: rd_mux = count_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pc_q        <= '0;
      cnt_en_q    <= 1'b0;
      pwm_en_q    <= 1'b0;
      one_shot_q  <= 1'b0;
      overflow_q  <= 1'b0;
      irq_q       <= 1'b0;
      func_sh_q   <= '0;
      func_q      <= '0;
      period_sh_q <= '0;
      cmp1_sh_q   <= '0;
      cmp2_sh_q   <= '0;
      presc_sh_q  <= '0;
      period_q    <= '0;
      cmp1_q      <= '0;
      cmp2_q      <= '0;
      presc_q     <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      irq_q      <= wrap;
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rdata_q <= rd_mux;
      // Active copy takes the pre-write shadow values.
      if (copy) begin
        period_q <= period_sh_q;
        cmp1_q   <= cmp1_sh_q;
        cmp2_q   <= cmp2_sh_q;
        presc_q  <= presc_sh_q;
        func_q   <= func_sh_q;
      end
      if (ctrl_wr) begin
        cnt_en_q   <= wdata_i[0];
        pwm_en_q   <= wdata_i[1];
        func_sh_q  <= wdata_i[3:2];
        one_shot_q <= wdata_i[4];
      end else if (wrap && one_shot_q) begin
        cnt_en_q <= 1'b0;
      end
      if (wr_en_i && addr_i == 3'd1) period_sh_q <= wdata_i;
      if (wr_en_i && addr_i == 3'd2) cmp1_sh_q   <= wdata_i;
      if (wr_en_i && addr_i == 3'd3) cmp2_sh_q   <= wdata_i;
      if (wr_en_i && addr_i == 3'd4) presc_sh_q  <= wdata_i[PRESCALE_W-1:0];
      if (wrap) overflow_q <= 1'b1;
      else if (wr_en_i && addr_i == 3'd5 && wdata_i[1]) overflow_q <= 1'b0;
    end
  end

  assign rdata_o      = rdata_q;
  assign rd_valid_o   = rd_valid_q;
  assign count_val_o  = count_q;
  assign period_o     = period_q;
  assign compare1_o   = cmp1_q;
  assign compare2_o   = cmp2_q;
  assign functions_o  = func_q;
  assign pwm_en_o     = pwm_en_q;
  assign period_irq_o = irq_q;

endmodule

// File: tb/tb_pwm_counter_ctrl.sv
// Bench for pwm_counter_ctrl: directed scenarios plus random register traffic, all checked
// cycle by cycle against a behavioural model of the register map and counter.
module tb_pwm_counter_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, wr_en, rd_en;
  logic [2:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata_o, count_val_o, period_o, compare1_o, compare2_o;
  logic [1:0]   functions_o;
  logic         rd_valid_o, pwm_en_o, period_irq_o;

  always #5 clk = ~clk;

  pwm_counter_ctrl #(.WIDTH(W), .PRESCALE_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .rd_en_i     (rd_en),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata_o),
    .rd_valid_o  (rd_valid_o),
    .count_val_o (count_val_o),
    .period_o    (period_o),
    .compare1_o  (compare1_o),
    .compare2_o  (compare2_o),
    .functions_o (functions_o),
    .pwm_en_o    (pwm_en_o),
    .period_irq_o(period_irq_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 = stopped, 1 = loading, 2 = counting.
  int m_mode, m_cnt, m_pc, m_cnt_en, m_pwm_en, m_fsh, m_os, m_ovf;
  int m_psh, m_c1sh, m_c2sh, m_prsh, m_per, m_c1, m_c2, m_fn, m_pr;
  int m_irq, m_rv, m_rdata;
  int cyc_no = 0, last_irq = -1, exp_gap = 0, irq_cnt = 0;

  function automatic int reg_view(input int a);
    case (a)
      0: return m_cnt_en | (m_pwm_en << 1) | (m_fsh << 2) | (m_os << 4);
      1: return m_psh;
      2: return m_c1sh;
      3: return m_c2sh;
      4: return m_prsh;
      5: return ((m_mode != 0) ? 1 : 0) | (m_ovf << 1);
      6: return m_cnt;
      default: return 0;
    endcase
  endfunction

  function automatic bit wrap_next();
    int eff;
    eff = (m_per == 0) ? 1 : m_per;
    return (m_mode == 2) && (m_pc == m_pr) && (m_cnt >= eff - 1);
  endfunction

  task automatic model_step(input bit r, input bit w, input bit rd, input int a,
                            input logic [15:0] d);
    int  n_mode, n_cnt, n_pc, eff;
    bit  wrap, copy, cw;
    if (r) begin
      {m_mode, m_cnt, m_pc, m_cnt_en, m_pwm_en, m_fsh, m_os, m_ovf} = '0;
      {m_psh, m_c1sh, m_c2sh, m_prsh, m_per, m_c1, m_c2, m_fn, m_pr} = '0;
      {m_irq, m_rv, m_rdata} = '0;
      return;
    end
    if (rd) m_rdata = reg_view(a);
    m_rv   = rd;
    cw     = w && (a == 0);
    n_mode = m_mode; n_cnt = m_cnt; n_pc = m_pc;
    wrap   = 0;
    copy   = (m_mode != 2);
    eff    = (m_per == 0) ? 1 : m_per;
    if (m_mode == 0) begin
      if (cw && d[0]) n_mode = 1;
    end else if (m_mode == 1) begin
      n_cnt = 0; n_pc = 0;
      n_mode = (cw && !d[0]) ? 0 : 2;
    end else begin
      if (cw && !d[0]) n_mode = 0;
      else if (m_pc == m_pr) begin
        n_pc = 0;
        if (m_cnt >= eff - 1) wrap = 1;
        else n_cnt = m_cnt + 1;
      end else n_pc = (m_pc + 1) & 8'hFF;
    end
    if (cw && d[5]) begin n_cnt = 0; n_pc = 0; wrap = 0; end
    if (wrap) begin
      n_cnt = 0; copy = 1;
      if (m_os != 0) n_mode = 0;
    end
    m_irq = wrap;
    if (copy) begin
      m_per = m_psh; m_c1 = m_c1sh; m_c2 = m_c2sh; m_pr = m_prsh; m_fn = m_fsh;
    end
    if (wrap) m_ovf = 1;
    else if (w && a == 5 && d[1]) m_ovf = 0;
    if (cw) begin
      m_cnt_en = d[0]; m_pwm_en = d[1]; m_fsh = d[3:2]; m_os = d[4];
    end else if (wrap && m_os != 0) m_cnt_en = 0;
    if (w && a == 1) m_psh  = d;
    if (w && a == 2) m_c1sh = d;
    if (w && a == 3) m_c2sh = d;
    if (w && a == 4) m_prsh = d[7:0];
    m_mode = n_mode; m_cnt = n_cnt; m_pc = n_pc;
  endtask

  task automatic cyc(input bit r, input bit w, input bit rd, input int a, input logic [15:0] d);
    rst = r; wr_en = w; rd_en = rd; addr = a[2:0]; wdata = d;
    @(posedge clk);
    model_step(r, w, rd, a, d);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    cyc_no++;
    check_eq("count_val", count_val_o, m_cnt);
    check_eq("period", period_o, m_per);
    check_eq("compare1", compare1_o, m_c1);
    check_eq("compare2", compare2_o, m_c2);
    check_eq("functions", functions_o, m_fn);
    check_eq("pwm_en", pwm_en_o, m_pwm_en);
    check_eq("period_irq", period_irq_o, m_irq);
    check_eq("rd_valid", rd_valid_o, m_rv);
    if (m_rv != 0) check_eq("rdata", rdata_o, m_rdata);
    if (period_irq_o === 1'b1) begin
      irq_cnt++;
      if (exp_gap != 0 && last_irq >= 0) check_eq("irq_gap", cyc_no - last_irq, exp_gap);
      last_irq = cyc_no;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0);
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    cyc(0, 1, 0, a, d);
  endtask
  task automatic rd(input int a);
    cyc(0, 0, 1, a, 16'h0);
  endtask

  initial begin
    int a, budget;
    bit r, w, rv;
    logic [15:0] d;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) rd(i);

    // Period 10, prescale 0: wrap every 10 clocks.
    wr(1, 16'd10); wr(2, 16'd3); wr(3, 16'd7);
    wr(0, 16'h01);
    exp_gap = 10; last_irq = -1;
    idle(35);
    exp_gap = 0;
    check_eq("per10", period_o, 10);

    // Shrink period mid-count; takes effect at the wrap, readback immediate.
    budget = 0;
    while (!(m_mode == 2 && m_cnt == 3) && budget < 30) begin idle(1); budget++; end
    check_eq("wait_cnt3", budget < 30, 1);
    wr(1, 16'd5);
    rd(1);
    check_eq("per_rd", rdata_o, 5);
    check_eq("per_hold", period_o, 10);
    idle(20);
    check_eq("per5", period_o, 5);

    // Stop at 7, cnt_reset, restart through LOAD.
    wr(1, 16'd10);
    budget = 0;
    while (!(m_mode == 2 && m_cnt == 7 && m_per == 10) && budget < 40) begin
      idle(1); budget++;
    end
    check_eq("wait_cnt7", budget < 40, 1);
    wr(0, 16'h00);
    idle(4);
    check_eq("stop_hold", count_val_o, 7);
    wr(0, 16'h20);
    check_eq("cnt_reset", count_val_o, 0);
    wr(0, 16'h01);
    idle(1);
    check_eq("restart0", count_val_o, 0);
    idle(1);
    check_eq("restart1", count_val_o, 1);

    // Prescale 2, period 4: 3 clocks per value, wrap every 12.
    wr(4, 16'd2); wr(1, 16'd4);
    budget = 0;
    while (!(m_pr == 2 && m_per == 4) && budget < 40) begin idle(1); budget++; end
    check_eq("wait_presc", budget < 40, 1);
    exp_gap = 12; last_irq = -1;
    idle(40);
    exp_gap = 0;

    // One-shot, period 6.
    wr(0, 16'h00); wr(4, 16'd0); wr(1, 16'd6); wr(5, 16'h2);
    irq_cnt = 0;
    wr(0, 16'h11);
    idle(15);
    check_eq("os_irqs", irq_cnt, 1);
    rd(0);
    check_eq("os_ctrl", rdata_o, 16'h10);
    rd(5);
    check_eq("os_status", rdata_o, 16'h2);

    // W1C on the wrap cycle leaves overflow set.
    wr(1, 16'd4); wr(5, 16'h2); wr(0, 16'h03);
    budget = 0;
    while (!wrap_next() && budget < 30) begin idle(1); budget++; end
    check_eq("wait_wrap", budget < 30, 1);
    wr(5, 16'h2);
    rd(5);
    check_eq("w1c_wrap", rdata_o[1], 1);

    // Reset mid-run.
    idle(3);
    cyc(1, 0, 1, 6, 16'h0);
    check_eq("rst_cnt", count_val_o, 0);
    check_eq("rst_per", period_o, 0);
    check_eq("rst_pwm", pwm_en_o, 0);
    check_eq("rst_rv", rd_valid_o, 0);
    check_eq("rst_irq", period_irq_o, 0);

    // Random register traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      w  = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 7);
      d  = 16'($urandom);
      if (a == 0) begin
        d = '0;
        d[0]   = ($urandom_range(0, 3) != 0);
        d[1]   = 1'($urandom_range(0, 1));
        d[3:2] = 2'($urandom_range(0, 3));
        d[4]   = ($urandom_range(0, 3) == 0);
        d[5]   = ($urandom_range(0, 15) == 0);
      end else if (a == 1) d = 16'($urandom_range(0, 12));
      else if (a == 4) d = 16'($urandom_range(0, 3));
      cyc(r, w, rv, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_counter_ctrl.md
Name: pwm_counter_ctrl

Overview:
- Timebase and configuration controller for pwm_gen.
- Owns a register file written over a simple strobe interface and generates count_val with a prescaler.
- Double-buffers period, compare1, compare2, functions and prescale, so new settings take effect only at a period boundary.
- Drives the pwm_gen inputs directly; pwm_gen stays purely a comparator.

Parameters:
- WIDTH, 16, width of count, period and compare values.
- PRESCALE_W, 8, width of the prescale register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe; always accepted in the same cycle.
- rd_en  in  1  register read strobe.
- addr  in  3  register address, shared by read and write.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data, registered.
- rd_valid  out  1  one-cycle pulse, rdata valid.
- count_val  out  WIDTH  counter to pwm_gen.
- period  out  WIDTH  active period to pwm_gen.
- compare1  out  WIDTH  active compare1.
- compare2  out  WIDTH  active compare2.
- functions  out  2  active mode (00 left, 01 right, 10 between compares).
- pwm_en  out  1  PWM output enable to pwm_gen.
- period_irq  out  1  one-cycle pulse per counter wrap.

Behaviour:
- Register map:
  - 0 CTRL: bit0 cnt_en, bit1 pwm_en, bits3:2 functions, bit4 one_shot, bit5 cnt_reset (write-only, self-clearing, reads 0).
  - 1 PERIOD, 2 COMPARE1, 3 COMPARE2, 4 PRESCALE (low PRESCALE_W bits).
  - 5 STATUS: bit0 running (RO), bit1 overflow (sticky, write-1-to-clear).
  - 6 COUNT (RO).
  - Unused addresses read 0; writes to them are ignored.
- Writes to PERIOD, COMPARE1, COMPARE2, PRESCALE and CTRL.functions go to shadow registers. Reads of these registers return the shadow values.
- pwm_en output follows CTRL.pwm_en one cycle after the write (not shadowed).
- Read latency: rdata/rd_valid are valid on the cycle after the rd_en edge. A simultaneous read and write of the same address returns the pre-write value.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: count_val and the prescale counter hold. Shadow-to-active copy happens every cycle.
    - Exit: cnt_en written 1 -> LOAD.
  - LOAD (1 cycle): shadow-to-active copy; count_val=0; prescale counter=0.
    - Exit -> RUN.
  - RUN: the prescale counter pc increments each clock. When pc==prescale_active, pc goes to 0 and a tick occurs.
    - On a tick, if count_val >= eff_period-1, count_val wraps to 0. eff_period = max(period_active,1); the >= comparison also covers a period that shrank.
    - On a tick that does not wrap, count_val increments by 1.
    - On a wrap: shadow-to-active copy, period_irq=1 for one cycle, STATUS.overflow set. If one_shot=1, CTRL.cnt_en clears and the state goes to IDLE with count_val=0.
    - Exit: cnt_en written 0 -> IDLE next cycle. count_val freezes at its current value; no wrap is generated.
- Start timing: with cnt_en written at edge E, the state is LOAD after E and RUN after E+1. With prescale 0, the first increment (count_val=1) occurs at edge E+2.
- cnt_reset: zeroes count_val and pc in any state. It does not change the state or copy the shadows. If it coincides with a wrap, cnt_reset wins and no period_irq is generated.
- STATUS.overflow: a set and a W1C in the same cycle leave the bit set.
- running = (state != IDLE).
- Reset values:
  - All outputs 0; state IDLE.
  - All shadow and active registers 0.
  - CTRL 0, STATUS 0.
- Reset mid-RUN returns to IDLE with everything zeroed on the next edge.
- All arithmetic is unsigned and WIDTH bits wide. count_val never exceeds eff_period-1 in RUN.

Test Plan:
- Period 10, prescale 0, functions 00, cnt_en=1 -> count_val cycles 0..9; period_irq pulses exactly every 10 clocks; period output = 10.
- Running with period 10: write PERIOD=5 when count_val=3 -> count continues to 9 and wraps; the next sequence is 0..4; the period output changes on the wrap cycle; reading PERIOD returns 5 immediately.
- Prescale 2, period 4 -> each count_val value is held 3 clocks; wrap every 12 clocks.
- one_shot=1, period 6 -> a single 0..5 sequence, one period_irq, then IDLE; CTRL reads back cnt_en=0; STATUS reads running=0, overflow=1.
- Stop at count_val=7 (cnt_en=0) -> count_val holds 7 with no irq. Then cnt_reset -> 0. Then restart -> LOAD, counting from 0.
- Overflow W1C written on the same cycle as a wrap -> bit stays 1. rst asserted mid-RUN -> all outputs 0 on the next edge; rd_valid 0.
